// File: rtl/pipeline_interlock_ctrl.sv
// Stall/flush sequencer: load-use interlock, multi-cycle memory freeze, branch shadow flush, memory watchdog.
// Latency: control outputs are combinational from state and inputs; counters update on the next gclk edge.
// Backpressure: mem_ready=0 freezes the whole pipe until ready or until the watchdog aborts the access.
module pipeline_interlock_ctrl #(
  parameter int ADDR_W    = 3,
  parameter int BR_SHADOW = 1,
  parameter int MAX_WAIT  = 15
) (
  input  logic              gclk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_dst_re,
  input  logic              id_src_re,
  input  logic              id_ext_re,
  input  logic [ADDR_W-1:0] id_dst_addr,
  input  logic [ADDR_W-1:0] id_src_addr,
  input  logic [ADDR_W-1:0] id_ext_addr,
  input  logic              alu_wb_en,
  input  logic [ADDR_W-1:0] alu_wb_addr,
  input  logic              alu_is_load,
  input  logic              br_taken,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_hold,
  output logic              ifid_hold,
  output logic              ifid_flush,
  output logic              idalu_bubble,
  output logic              back_hold,
  output logic              mem_abort,
  output logic              mem_timeout,
  output logic [15:0]       stall_cycles
);

  typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT} state_t;

  localparam logic [2:0] SHADOW_INIT = 3'(BR_SHADOW);
  localparam logic [7:0] WAIT_LIMIT  = 8'(MAX_WAIT);

  state_t     state, state_nxt, ret_state, ret_state_nxt, eval_state;
  logic [2:0] shadow_cnt, shadow_cnt_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       mstall, luse, eval_mstall, resolve;
  logic       pc_hold_c, ifid_hold_c, ifid_flush_c, idalu_bubble_c, back_hold_c, mem_abort_c;

  assign mstall = mem_req & ~mem_ready;
  assign luse   = id_valid & alu_is_load & alu_wb_en &
                  ((id_dst_re & (id_dst_addr == alu_wb_addr)) |
                   (id_src_re & (id_src_addr == alu_wb_addr)) |
                   (id_ext_re & (id_ext_addr == alu_wb_addr)));

  always_comb begin
    state_nxt      = state;
    ret_state_nxt  = ret_state;
    shadow_cnt_nxt = shadow_cnt;
    wait_cnt_nxt   = wait_cnt;
    pc_hold_c      = 1'b0;
    ifid_hold_c    = 1'b0;
    ifid_flush_c   = 1'b0;
    idalu_bubble_c = 1'b0;
    back_hold_c    = 1'b0;
    mem_abort_c    = 1'b0;
    eval_state     = state;
    eval_mstall    = mstall;
    resolve        = 1'b1;

    // Leaving MEM_WAIT (ready or watchdog) re-evaluates the interrupted state with the stall masked.
    if (state == MEM_WAIT) begin
      eval_state  = ret_state;
      eval_mstall = 1'b0;
      if (!mem_ready && (wait_cnt < WAIT_LIMIT)) begin
        resolve      = 1'b0;
        pc_hold_c    = 1'b1;
        ifid_hold_c  = 1'b1;
        back_hold_c  = 1'b1;
        wait_cnt_nxt = wait_cnt + 8'd1;
      end else begin
        wait_cnt_nxt = 8'd0;
        mem_abort_c  = ~mem_ready;
      end
    end

    if (resolve) begin
      state_nxt = eval_state;
      if (eval_mstall) begin
        pc_hold_c     = 1'b1;
        ifid_hold_c   = 1'b1;
        back_hold_c   = 1'b1;
        state_nxt     = MEM_WAIT;
        ret_state_nxt = eval_state;
        wait_cnt_nxt  = 8'd1;
      end else if (br_taken) begin
        ifid_flush_c   = 1'b1;
        idalu_bubble_c = 1'b1;
        if (BR_SHADOW > 0) begin
          state_nxt      = FLUSH;
          shadow_cnt_nxt = SHADOW_INIT;
        end
      end else if (eval_state == FLUSH) begin
        // The ID slot holds a flushed NOP here, so load-use is irrelevant.
        ifid_flush_c   = 1'b1;
        shadow_cnt_nxt = shadow_cnt - 3'd1;
        if (shadow_cnt == 3'd1) state_nxt = RUN;
      end else if (luse) begin
        pc_hold_c      = 1'b1;
        ifid_hold_c    = 1'b1;
        idalu_bubble_c = 1'b1;
      end
    end
  end

  assign pc_hold      = pc_hold_c      & ~rst;
  assign ifid_hold    = ifid_hold_c    & ~rst;
  assign ifid_flush   = ifid_flush_c   & ~rst;
  assign idalu_bubble = idalu_bubble_c & ~rst;
  assign back_hold    = back_hold_c    & ~rst;
  assign mem_abort    = mem_abort_c    & ~rst;

  always_ff @(posedge gclk or posedge rst) begin
    if (rst) begin
      state        <= RUN;
      ret_state    <= RUN;
      shadow_cnt   <= 3'd0;
      wait_cnt     <= 8'd0;
      mem_timeout  <= 1'b0;
      stall_cycles <= 16'd0;
    end else begin
      state      <= state_nxt;
      ret_state  <= ret_state_nxt;
      shadow_cnt <= shadow_cnt_nxt;
      wait_cnt   <= wait_cnt_nxt;
      if (mem_abort_c) mem_timeout <= 1'b1;
      if (pc_hold_c && (stall_cycles != 16'hFFFF)) stall_cycles <= stall_cycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_interlock_ctrl.sv
// Bench for pipeline_interlock_ctrl: two parameterisations driven in parallel, checked every cycle
// against a behavioural model, plus directed scenarios with literal expectations.
module tb_pipeline_interlock_ctrl;

  localparam int SH_A = 1, MW_A = 4;
  localparam int SH_B = 3, MW_B = 6;

  logic       gclk = 1'b0;
  logic       rst;
  logic       id_valid, id_dst_re, id_src_re, id_ext_re;
  logic [2:0] id_dst_addr, id_src_addr, id_ext_addr, alu_wb_addr;
  logic       alu_wb_en, alu_is_load, br_taken, mem_req, mem_ready;

  logic        a_pc, a_ih, a_fl, a_bb, a_bh, a_ab, a_to;
  logic        b_pc, b_ih, b_fl, b_bb, b_bh, b_ab, b_to;
  logic [15:0] stall_a, stall_b;
  logic [6:0]  ctl_a, ctl_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 gclk = ~gclk;

  pipeline_interlock_ctrl #(.ADDR_W(3), .BR_SHADOW(SH_A), .MAX_WAIT(MW_A)) dut_a (
    .gclk(gclk), .rst(rst), .id_valid(id_valid), .id_dst_re(id_dst_re), .id_src_re(id_src_re),
    .id_ext_re(id_ext_re), .id_dst_addr(id_dst_addr), .id_src_addr(id_src_addr),
    .id_ext_addr(id_ext_addr), .alu_wb_en(alu_wb_en), .alu_wb_addr(alu_wb_addr),
    .alu_is_load(alu_is_load), .br_taken(br_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_hold(a_pc), .ifid_hold(a_ih), .ifid_flush(a_fl), .idalu_bubble(a_bb), .back_hold(a_bh),
    .mem_abort(a_ab), .mem_timeout(a_to), .stall_cycles(stall_a));

  pipeline_interlock_ctrl #(.ADDR_W(3), .BR_SHADOW(SH_B), .MAX_WAIT(MW_B)) dut_b (
    .gclk(gclk), .rst(rst), .id_valid(id_valid), .id_dst_re(id_dst_re), .id_src_re(id_src_re),
    .id_ext_re(id_ext_re), .id_dst_addr(id_dst_addr), .id_src_addr(id_src_addr),
    .id_ext_addr(id_ext_addr), .alu_wb_en(alu_wb_en), .alu_wb_addr(alu_wb_addr),
    .alu_is_load(alu_is_load), .br_taken(br_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_hold(b_pc), .ifid_hold(b_ih), .ifid_flush(b_fl), .idalu_bubble(b_bb), .back_hold(b_bh),
    .mem_abort(b_ab), .mem_timeout(b_to), .stall_cycles(stall_b));

  // {pc_hold, ifid_hold, ifid_flush, idalu_bubble, back_hold, mem_abort, mem_timeout}
  assign ctl_a = {a_pc, a_ih, a_fl, a_bb, a_bh, a_ab, a_to};
  assign ctl_b = {b_pc, b_ih, b_fl, b_bb, b_bh, b_ab, b_to};

  function automatic void chk(string nm, logic [15:0] act, logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endfunction

  // Behavioural model: shadow_left>0 means branch shadow pending; waiting/waited track a memory freeze.
  int sh_cfg[2] = '{SH_A, SH_B};
  int mw_cfg[2] = '{MW_A, MW_B};
  int m_shadow[2], m_waited[2], m_stall[2];
  bit m_wait[2], m_to[2];

  always @(negedge gclk) begin
    for (int i = 0; i < 2; i++) begin
      logic [6:0]  act, exp;
      logic [15:0] act_stall;
      bit ph, ih, fl, bb, bh, ab, mst, lu, resume;
      act       = (i == 0) ? ctl_a : ctl_b;
      act_stall = (i == 0) ? stall_a : stall_b;
      if (rst) begin
        chk($sformatf("reset_ctl%0d", i), 16'(act), 16'd0);
        chk($sformatf("reset_stall%0d", i), act_stall, 16'd0);
        m_shadow[i] = 0; m_waited[i] = 0; m_stall[i] = 0; m_wait[i] = 0; m_to[i] = 0;
      end else begin
        {ph, ih, fl, bb, bh, ab} = 6'b0;
        mst = mem_req && !mem_ready;
        lu  = id_valid && alu_is_load && alu_wb_en &&
              ((id_dst_re && id_dst_addr == alu_wb_addr) ||
               (id_src_re && id_src_addr == alu_wb_addr) ||
               (id_ext_re && id_ext_addr == alu_wb_addr));
        if (m_wait[i] && !mem_ready && m_waited[i] < mw_cfg[i]) begin
          ph = 1; ih = 1; bh = 1;
          m_waited[i]++;
        end else begin
          resume = m_wait[i];
          ab = resume && !mem_ready;
          if (!resume && mst) begin
            ph = 1; ih = 1; bh = 1;
            m_wait[i] = 1; m_waited[i] = 1;
          end else if (br_taken) begin
            fl = 1; bb = 1; m_shadow[i] = sh_cfg[i];
          end else if (m_shadow[i] > 0) begin
            fl = 1; m_shadow[i]--;
          end else if (lu) begin
            ph = 1; ih = 1; bb = 1;
          end
          if (resume) begin m_wait[i] = 0; m_waited[i] = 0; end
        end
        exp = {ph, ih, fl, bb, bh, ab, m_to[i]};
        chk($sformatf("model_ctl%0d", i), 16'(act), 16'(exp));
        chk($sformatf("model_stall%0d", i), act_stall, 16'(m_stall[i]));
        if (ab) m_to[i] = 1;
        if (ph && m_stall[i] < 65535) m_stall[i]++;
      end
    end
  end

  task automatic smp();
    @(negedge gclk);
  endtask

  task automatic nxt();
    @(posedge gclk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_dst_re = 0; id_src_re = 0; id_ext_re = 0;
    id_dst_addr = 0; id_src_addr = 0; id_ext_addr = 0;
    alu_wb_en = 0; alu_wb_addr = 0; alu_is_load = 0;
    br_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic load_use();
    idle();
    alu_is_load = 1; alu_wb_en = 1; alu_wb_addr = 3'd3;
    id_valid = 1; id_src_re = 1; id_src_addr = 3'd3;
  endtask

  task automatic rand_inputs();
    id_valid    = $urandom_range(0, 3) != 0;
    id_dst_re   = $urandom_range(0, 1) != 0;
    id_src_re   = $urandom_range(0, 1) != 0;
    id_ext_re   = $urandom_range(0, 1) != 0;
    id_dst_addr = 3'($urandom_range(0, 7));
    id_src_addr = 3'($urandom_range(0, 7));
    id_ext_addr = 3'($urandom_range(0, 7));
    alu_wb_addr = 3'($urandom_range(0, 7));
    alu_wb_en   = $urandom_range(0, 3) != 0;
    alu_is_load = $urandom_range(0, 1) != 0;
    br_taken    = $urandom_range(0, 7) == 0;
    mem_req     = $urandom_range(0, 2) == 0;
    mem_ready   = $urandom_range(0, 4) < 2;
    rst         = $urandom_range(0, 199) == 0;
  endtask

  initial begin
    idle();
    rst = 1;
    smp();
    chk("reset_outputs", 16'(ctl_a), 16'd0);
    chk("reset_stall", stall_a, 16'd0);
    nxt(); rst = 0;

    // Load-use: one hold+bubble cycle, then clear.
    load_use();
    smp(); chk("luse_hold", 16'(ctl_a), 16'(7'b1101000));
    nxt(); idle();
    smp(); chk("luse_after", 16'(ctl_a), 16'd0);
    chk("luse_stall", stall_a, 16'd1);

    // Non-hits.
    nxt(); load_use(); id_src_re = 0;
    smp(); chk("nohit_re", 16'(ctl_a), 16'd0);
    nxt(); load_use(); alu_is_load = 0;
    smp(); chk("nohit_load", 16'(ctl_a), 16'd0);

    // Taken branch with one shadow cycle.
    nxt(); idle(); br_taken = 1;
    smp(); chk("br_cycle", 16'(ctl_a), 16'(7'b0011000));
    nxt(); idle();
    smp(); chk("br_shadow", 16'(ctl_a), 16'(7'b0010000));
    nxt();
    smp(); chk("br_done", 16'(ctl_a), 16'd0);

    // Memory wait of 3 cycles.
    for (int k = 0; k < 3; k++) begin
      nxt(); idle(); mem_req = 1;
      smp(); chk($sformatf("mwait_%0d", k), 16'(ctl_a), 16'(7'b1100100));
    end
    nxt(); mem_ready = 1;
    smp(); chk("mwait_release", 16'(ctl_a), 16'd0);
    chk("mwait_stall", stall_a, 16'd4);

    // Watchdog: 4 freeze cycles then abort.
    for (int k = 0; k < 4; k++) begin
      nxt(); idle(); mem_req = 1;
      smp(); chk($sformatf("wd_hold_%0d", k), 16'(ctl_a), 16'(7'b1100100));
    end
    nxt();
    smp(); chk("wd_abort", 16'(ctl_a), 16'(7'b0000010));
    chk("wd_stall", stall_a, 16'd8);
    nxt(); idle();
    smp(); chk("wd_sticky", 16'(ctl_a), 16'(7'b0000001));
    repeat (2) begin nxt(); smp(); end

    // Memory stall coincident with branch: branch acts at release.
    for (int k = 0; k < 2; k++) begin
      nxt(); idle(); mem_req = 1; br_taken = 1;
      smp(); chk($sformatf("co_freeze_%0d", k), 16'(ctl_a), 16'(7'b1100101));
    end
    nxt(); mem_ready = 1;
    smp(); chk("co_release", 16'(ctl_a), 16'(7'b0011001));
    nxt(); idle();
    smp(); chk("co_shadow", 16'(ctl_a), 16'(7'b0010001));
    nxt();
    smp(); chk("co_done", 16'(ctl_a), 16'(7'b0000001));

    // Reset in the middle of a freeze.
    nxt(); mem_req = 1;
    smp(); chk("rst_pre", 16'(ctl_a), 16'(7'b1100101));
    nxt(); #2 rst = 1;
    smp(); chk("rst_mid_ctl", 16'(ctl_a), 16'd0);
    chk("rst_mid_stall", stall_a, 16'd0);
    nxt(); rst = 0; idle();

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      nxt(); rand_inputs();
    end
    nxt(); idle(); rst = 1;
    nxt(); rst = 0;

    // Continuous stall pressure to saturate the counter.
    load_use(); mem_req = 1;
    repeat (66000) nxt();
    smp();
    chk("sat_a", stall_a, 16'hFFFF);
    chk("sat_b", stall_b, 16'hFFFF);
    nxt(); idle();
    smp();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
